// File: rtl/intr_rx_pkg.sv
// Shared types and constants for the interrupt-vector receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum/width, width-counter width, index-width helper.
package intr_rx_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Request width counter, saturating at its maximum value.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index width for an N-source one-hot vector; never zero so a 1-source
  // build still has a legal bus.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_rx_fifo.sv
// Synchronous show-ahead FIFO: head data is valid whenever o_empty is low.
// Latency: a write into an empty FIFO is visible the following cycle.
// Backpressure: a write while full is accepted only if a read happens in the same cycle.
// Ports: clk, rst (sync, high), i_wr_vld/i_wr_dat write side,
//        i_rd_rdy pop request, o_rd_dat head, o_empty, o_full.
module intr_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_rdy,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_empty,
  output logic             o_full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_pop  = i_rd_rdy && !o_empty;
  assign w_push = i_wr_vld && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/priority_encoder.sv
// Priority encoder: binary index and isolated one-hot of the winning set bit.
// Latency: combinational.
// Backpressure: none.
// Ports: input_unencoded (vector), output_valid (any bit set),
//        output_encoded (winning index), output_unencoded (winning bit only).
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter bit LSB_HIGH_PRIORITY = 0,
  parameter int ENC_W             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [ENC_W-1:0] output_encoded,
  output logic [WIDTH-1:0] output_unencoded
);

  always_comb begin
    output_valid   = |input_unencoded;
    output_encoded = '0;
    if (LSB_HIGH_PRIORITY) begin
      // Scan downward so the lowest set bit is the last (winning) assignment.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) output_encoded = ENC_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = ENC_W'(i);
      end
    end
    output_unencoded = output_valid ? (WIDTH'(1) << output_encoded) : '0;
  end

endmodule

// File: rtl/intr_vec_receiver.sv
// Interrupt-vector link receiver: validates one-hot request pulses, queues their indices.
// Latency: req high in cycle 0, low in cycle 1 -> COMMIT in cycle 2 -> event/pending in cycle 3.
// Backpressure: valid/ready on the event side; a legal request arriving at a full queue is dropped and flagged.
// Ports: clk, rst (sync, high); i_intr_vec_req/i_intr_num request link;
//        o_evt_valid/i_evt_ready/o_evt_index event queue head; o_pending per-source bits;
//        o_overflow/o_proto_err sticky flags cleared by i_err_clr; o_dup_count coalesce count.
// Build option: define INTR_RX_COALESCE_EN to drop duplicates of an already-pending source.
module intr_vec_receiver
  import intr_rx_pkg::*;
#(
  parameter  int PORTS          = 4,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int MIN_REQ_CYCLES = 1,
  localparam int IDX_W          = idx_w(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_intr_vec_req,
  input  logic [31:0]      i_intr_num,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [IDX_W-1:0] o_evt_index,
  output logic [PORTS-1:0] o_pending,
  output logic             o_overflow,
  output logic             o_proto_err,
  input  logic             i_err_clr,
  output logic [7:0]       o_dup_count
);

  localparam logic [31:0] PORT_MASK =
    (PORTS >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << PORTS) - 64'd1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req_d;
  logic [31:0]      r_latched;
  logic [CNT_W-1:0] r_cnt;
  logic             r_chg;

  logic             w_load;
  logic             w_track;
  logic             w_commit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_intr_vec_req && !r_req_d) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!i_intr_vec_req)            w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = i_intr_vec_req ? ST_ACTIVE : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // COMMIT accepts a new request without needing a rising edge, so a pulse
  // that restarts exactly in the commit cycle is taken back-to-back.
  always_comb begin
    w_load   = 1'b0;
    w_track  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE:   w_load = i_intr_vec_req && !r_req_d;
      ST_ACTIVE: w_track = i_intr_vec_req;
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_load   = i_intr_vec_req;
      end
      default: ;
    endcase
  end

  // Request capture. r_req_d resets high so a strobe already asserted when
  // reset releases must fall before it can be seen as a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d   <= 1'b1;
      r_latched <= '0;
      r_cnt     <= '0;
      r_chg     <= 1'b0;
    end else begin
      r_req_d <= i_intr_vec_req;
      if (w_load) begin
        r_latched <= i_intr_num;
        r_cnt     <= CNT_W'(1);
        r_chg     <= 1'b0;
      end else if (w_track) begin
        if (r_cnt != CNT_MAX)         r_cnt <= r_cnt + CNT_W'(1);
        if (i_intr_num != r_latched)  r_chg <= 1'b1;
      end
    end
  end

  // ---------------- Validation ----------------
  logic             w_enc_vld;
  logic [IDX_W-1:0] w_enc_idx;
  logic [PORTS-1:0] w_enc_unenc;
  logic             w_legal;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1'b1),
    .ENC_W             (IDX_W)
  ) u_enc (
    .input_unencoded  (r_latched[PORTS-1:0]),
    .output_valid     (w_enc_vld),
    .output_encoded   (w_enc_idx),
    .output_unencoded (w_enc_unenc)
  );

  // One-hot iff the isolated lowest set bit is the whole vector.
  assign w_legal = w_enc_vld
                && (w_enc_unenc == r_latched[PORTS-1:0])
                && ((r_latched & ~PORT_MASK) == 32'd0)
                && !r_chg
                && (r_cnt >= CNT_W'(MIN_REQ_CYCLES));

  // ---------------- Event queue ----------------
  logic             w_empty;
  logic             w_full;
  logic [IDX_W-1:0] w_head;
  logic             w_pop;
  logic             w_dup;
  logic             w_wr_req;
  logic             w_wr;

  assign o_evt_valid = !w_empty;
  assign o_evt_index = o_evt_valid ? w_head : '0;
  assign w_pop       = o_evt_valid && i_evt_ready;

`ifdef INTR_RX_COALESCE_EN
  // A source already pending is folded in, unless its pending entry leaves
  // the queue this very cycle (then the new one must be queued to keep it).
  assign w_dup = o_pending[w_enc_idx] && !(w_pop && (w_head == w_enc_idx));
`else
  assign w_dup = 1'b0;
`endif

  assign w_wr_req = w_commit && w_legal && !w_dup;
  assign w_wr     = w_wr_req && (!w_full || w_pop);

  intr_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (w_wr),
    .i_wr_dat (w_enc_idx),
    .i_rd_rdy (w_pop),
    .o_rd_dat (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  // ---------------- Pending bits ----------------
  logic [PORTS-1:0] r_pending;
  logic [PORTS-1:0] w_clr_mask;
  logic [PORTS-1:0] w_set_mask;

  assign w_clr_mask = w_pop ? (PORTS'(1) << w_head)    : '0;
  assign w_set_mask = w_wr  ? (PORTS'(1) << w_enc_idx) : '0;

  // Set applied after clear so a same-index write and pop leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end
  assign o_pending = r_pending;

  // ---------------- Sticky flags ----------------
  logic r_overflow;
  logic r_proto_err;
  logic w_ovf_set;
  logic w_perr_set;

  assign w_ovf_set  = w_wr_req && w_full && !w_pop;
  assign w_perr_set = w_commit && !w_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow  <= 1'b1;
      else if (i_err_clr) r_overflow  <= 1'b0;
      if (w_perr_set)     r_proto_err <= 1'b1;
      else if (i_err_clr) r_proto_err <= 1'b0;
    end
  end
  assign o_overflow  = r_overflow;
  assign o_proto_err = r_proto_err;

  // ---------------- Duplicate counter ----------------
`ifdef INTR_RX_COALESCE_EN
  logic [7:0] r_dup_count;
  logic       w_dup_inc;

  assign w_dup_inc = w_commit && w_legal && w_dup;

  // A duplicate coinciding with a clear counts as the first after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dup_count <= '0;
    end else if (w_dup_inc) begin
      if (i_err_clr)                 r_dup_count <= 8'd1;
      else if (r_dup_count != 8'hFF) r_dup_count <= r_dup_count + 8'd1;
    end else if (i_err_clr) begin
      r_dup_count <= '0;
    end
  end
  assign o_dup_count = r_dup_count;
`else
  assign o_dup_count = 8'd0;
`endif

endmodule

// File: tb/tb_intr_vec_receiver.sv
module tb_intr_vec_receiver;

  localparam int PORTS = 4;
  localparam int DEPTH = 4;
  localparam int NCYC  = 600;
`ifdef INTR_RX_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] num;
  logic        rdy;
  logic        clr;
  logic        evt_valid;
  logic [1:0]  evt_index;
  logic [3:0]  pending;
  logic        overflow;
  logic        proto_err;
  logic [7:0]  dup_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  intr_vec_receiver #(
    .PORTS          (PORTS),
    .FIFO_DEPTH     (DEPTH),
    .MIN_REQ_CYCLES (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_intr_vec_req (req),
    .i_intr_num     (num),
    .o_evt_valid    (evt_valid),
    .i_evt_ready    (rdy),
    .o_evt_index    (evt_index),
    .o_pending      (pending),
    .o_overflow     (overflow),
    .o_proto_err    (proto_err),
    .i_err_clr      (clr),
    .o_dup_count    (dup_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; num = '0; rdy = 1'b0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // High for w cycles with value v, then one low cycle. The commit edge is the next tick.
  task automatic pulse(input logic [31:0] v, input int w);
    req = 1'b1; num = v;
    repeat (w) tick();
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; num = 32'h4; rdy = 1'b0; clr = 1'b0;
    tick(); tick();
    tests++;
    if ({evt_valid, evt_index, pending, overflow, proto_err, dup_count} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b i=%0d p=%h o=%0b e=%0b d=%0d want all 0",
               evt_valid, evt_index, pending, overflow, proto_err, dup_count);
    end
    req = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    do_reset();
    req = 1'b1; num = 32'h4; tick();
    req = 1'b0; tick();
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++; $display("FAIL single_early_valid: got %0b want 0", evt_valid);
    end
    tick();
    tests++;
    if ({evt_valid, evt_index, pending} !== {1'b1, 2'd2, 4'h4}) begin
      fails++;
      $display("FAIL single_event: got v=%0b i=%0d p=%h want v=1 i=2 p=4", evt_valid, evt_index, pending);
    end
    rdy = 1'b1; tick(); rdy = 1'b0;
    tests++;
    if ({evt_valid, pending} !== 5'd0) begin
      fails++; $display("FAIL single_pop: got v=%0b p=%h want v=0 p=0", evt_valid, pending);
    end
  endtask

  task automatic test_ordered();
    int exp_idx[3] = '{0, 1, 3};
    do_reset();
    pulse(32'h1, 1); pulse(32'h2, 1); pulse(32'h8, 1);
    tick();
    tests++;
    if (pending !== 4'hB) begin
      fails++; $display("FAIL ordered_pending: got %h want b", pending);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (evt_valid !== 1'b1 || evt_index !== 2'(exp_idx[k])) begin
        fails++;
        $display("FAIL ordered_pop%0d: got v=%0b i=%0d want v=1 i=%0d", k, evt_valid, evt_index, exp_idx[k]);
      end
      rdy = 1'b1; tick(); rdy = 1'b0;
    end
    tests++;
    if ({evt_valid, pending} !== 5'd0) begin
      fails++; $display("FAIL ordered_drained: got v=%0b p=%h want 0", evt_valid, pending);
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    do_reset();
    repeat (5) pulse(32'h1, 1);
    tick();
    tests++;
    if (overflow !== !COAL) begin
      fails++; $display("FAIL overflow_set: got %0b want %0b", overflow, !COAL);
    end
    tests++;
    if (dup_count !== (COAL ? 8'd4 : 8'd0)) begin
      fails++; $display("FAIL overflow_dup: got %0d want %0d", dup_count, COAL ? 4 : 0);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL overflow_clr: got %0b want 0", overflow);
    end
    rdy = 1'b1;
    for (int k = 0; k < 10 && evt_valid; k++) begin n++; tick(); end
    rdy = 1'b0;
    tests++;
    if (n != (COAL ? 1 : 4)) begin
      fails++; $display("FAIL overflow_entries: got %0d want %0d", n, COAL ? 1 : 4);
    end
  endtask

  task automatic test_proto_err();
    logic [31:0] bad[3] = '{32'h3, 32'h0, 32'h10};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      clr = 1'b1; tick(); clr = 1'b0;
      pulse(bad[k], 1); tick();
      tests++;
      if ({proto_err, evt_valid} !== 2'b10) begin
        fails++;
        $display("FAIL proto_%h: got e=%0b v=%0b want e=1 v=0", bad[k], proto_err, evt_valid);
      end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tests++;
    if (proto_err !== 1'b0) begin
      fails++; $display("FAIL proto_clr: got %0b want 0", proto_err);
    end
    req = 1'b1; num = 32'h1; tick();
    num = 32'h2; tick();
    req = 1'b0; tick(); tick();
    tests++;
    if ({proto_err, evt_valid} !== 2'b10) begin
      fails++; $display("FAIL proto_change: got e=%0b v=%0b want e=1 v=0", proto_err, evt_valid);
    end
    // Clear held across the commit edge of an illegal request: set wins.
    clr = 1'b1; pulse(32'h3, 1); tick(); clr = 1'b0;
    tests++;
    if (proto_err !== 1'b1) begin
      fails++; $display("FAIL proto_set_wins: got %0b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 1'b1; num = 32'h2; tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    repeat (3) tick();
    req = 1'b0; tick(); tick(); tick();
    tests++;
    if ({evt_valid, proto_err, pending} !== 6'd0) begin
      fails++;
      $display("FAIL resetmid_none: got v=%0b e=%0b p=%h want 0", evt_valid, proto_err, pending);
    end
    pulse(32'h2, 1); tick();
    tests++;
    if ({evt_valid, evt_index} !== {1'b1, 2'd1}) begin
      fails++; $display("FAIL resetmid_next: got v=%0b i=%0d want v=1 i=1", evt_valid, evt_index);
    end
  endtask

  task automatic test_coalesce();
    int n = 0;
    do_reset();
    pulse(32'h2, 1); pulse(32'h2, 1); tick();
    tests++;
    if (dup_count !== (COAL ? 8'd1 : 8'd0)) begin
      fails++; $display("FAIL coalesce_dup: got %0d want %0d", dup_count, COAL ? 1 : 0);
    end
    rdy = 1'b1;
    for (int k = 0; k < 10 && evt_valid; k++) begin n++; tick(); end
    rdy = 1'b0;
    tests++;
    if (n != (COAL ? 1 : 2)) begin
      fails++; $display("FAIL coalesce_entries: got %0d want %0d", n, COAL ? 1 : 2);
    end
  endtask

  // Random pulse stream against a queue-based model. A pulse of w high cycles
  // starting at edge s is committed at edge s+w+1.
  task automatic test_random();
    bit          s_req[NCYC];
    logic [31:0] s_num[NCYC];
    bit          s_rdy[NCYC];
    bit          s_clr[NCYC];
    bit          c_vld[NCYC];
    bit          c_legal[NCYC];
    int          c_idx[NCYC];
    int          q[$];
    bit [3:0]    m_pend = '0;
    bit          m_ovf = 1'b0, m_perr = 1'b0;
    int          m_dup = 0;
    int          c = 1;
    do_reset();
    for (int e = 0; e < NCYC; e++) begin
      s_req[e] = 1'b0; s_num[e] = $urandom; c_vld[e] = 1'b0; c_legal[e] = 1'b0; c_idx[e] = 0;
      s_rdy[e] = ($urandom_range(0, 9) < 3); s_clr[e] = ($urandom_range(0, 19) == 0);
    end
    while (c < NCYC - 12) begin
      int r = $urandom_range(0, 9);
      int w = $urandom_range(1, 3);
      logic [31:0] v0, v2;
      bit chg = 1'b0;
      if (r < 7)       v0 = 32'd1 << $urandom_range(0, 3);
      else if (r == 7) v0 = $urandom;
      else if (r == 8) v0 = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h6;
      else begin
        v0 = 32'd1 << $urandom_range(0, 3);
        v2 = v0 ^ (32'd1 << $urandom_range(0, 3));
        if (v2 == v0) v2 = v0 ^ 32'h10;
        chg = 1'b1;
        if (w < 2) w = 2;
      end
      for (int k = 0; k < w; k++) begin
        s_req[c+k] = 1'b1;
        s_num[c+k] = (chg && k >= 1) ? v2 : v0;
      end
      c_vld[c+w+1]   = 1'b1;
      c_legal[c+w+1] = ($countones(v0) == 1) && (v0 < 32'h10) && !chg;
      for (int b = 0; b < 4; b++) if (v0[b]) c_idx[c+w+1] = b;
      c = c + w + $urandom_range(1, 3);
    end
    for (int e = 0; e < NCYC; e++) begin
      bit pop, wr, ovf_set, perr_set, dup_inc;
      int pidx;
      req = s_req[e]; num = s_num[e]; rdy = s_rdy[e]; clr = s_clr[e];
      pop = (q.size() > 0) && s_rdy[e];
      pidx = pop ? q[0] : 0;
      wr = 1'b0; ovf_set = 1'b0; perr_set = 1'b0; dup_inc = 1'b0;
      if (c_vld[e]) begin
        if (!c_legal[e]) perr_set = 1'b1;
        else if (COAL && m_pend[c_idx[e]] && !(pop && pidx == c_idx[e])) dup_inc = 1'b1;
        else if (q.size() < DEPTH || pop) wr = 1'b1;
        else ovf_set = 1'b1;
      end
      tick();
      if (pop) begin void'(q.pop_front()); m_pend[pidx] = 1'b0; end
      if (wr)  begin q.push_back(c_idx[e]); m_pend[c_idx[e]] = 1'b1; end
      m_ovf  = ovf_set  || (m_ovf  && !s_clr[e]);
      m_perr = perr_set || (m_perr && !s_clr[e]);
      if (COAL) begin
        if (dup_inc)       m_dup = s_clr[e] ? 1 : ((m_dup < 255) ? m_dup + 1 : 255);
        else if (s_clr[e]) m_dup = 0;
      end
      tests++;
      if (evt_valid !== (q.size() > 0)) begin
        fails++; $display("FAIL rand_valid@%0d: got %0b want %0b", e, evt_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        tests++;
        if (evt_index !== 2'(q[0])) begin
          fails++; $display("FAIL rand_index@%0d: got %0d want %0d", e, evt_index, q[0]);
        end
      end
      tests++;
      if (pending !== m_pend) begin
        fails++; $display("FAIL rand_pending@%0d: got %h want %h", e, pending, m_pend);
      end
      tests++;
      if ({overflow, proto_err} !== {m_ovf, m_perr}) begin
        fails++;
        $display("FAIL rand_flags@%0d: got o=%0b e=%0b want o=%0b e=%0b", e, overflow, proto_err, m_ovf, m_perr);
      end
      tests++;
      if (dup_count !== 8'(m_dup)) begin
        fails++; $display("FAIL rand_dup@%0d: got %0d want %0d", e, dup_count, m_dup);
      end
    end
    req = 1'b0; rdy = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; num = '0; rdy = 1'b0; clr = 1'b0;
    test_reset();
    test_single_pulse();
    test_ordered();
    test_overflow();
    test_proto_err();
    test_reset_mid();
    test_coalesce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
